// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues request-to-send,
// shifts out one command byte with odd parity on device clock edges and checks the ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 5000,
    parameter int RTS_CYC     = 250,
    parameter int TIMEOUT_CYC = 750000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic [7:0] Cmd,
    inout  wire        M_CLK,
    inout  wire        M_Dat,
    output logic       Busy,
    output logic       Done,
    output logic       Err
);

    localparam int PW = $clog2(INHIBIT_CYC + RTS_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0] INH_LAST = PW'(INHIBIT_CYC - 1);
    localparam logic [PW-1:0] RTS_LAST = PW'(RTS_CYC - 1);
    localparam logic [TW-1:0] TMO_LIM  = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_MAX  = {TW{1'b1}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INHIBIT = 3'd1,
        RTS     = 3'd2,
        SEND    = 3'd3,
        ACK     = 3'd4,
        RELEASE = 3'd5
    } state_t;

    state_t        state_r;
    logic [7:0]    cmd_r;
    logic          par_r;
    logic [3:0]    bit_cnt_r;
    logic [PW-1:0] phase_cnt_r;
    logic [TW-1:0] tmo_cnt_r;
    logic          clk_low_r;
    logic          dat_low_r;
    logic [1:0]    clk_sync_r;
    logic [1:0]    dat_sync_r;
    logic          clk_prev_r;

    logic          clk_fall_s;
    logic [TW-1:0] tmo_inc_s;
    logic          timeout_s;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Open-drain pads: only ever pull low or float.
    assign M_CLK = clk_low_r ? 1'b0 : 1'bz;
    assign M_Dat = dat_low_r ? 1'b0 : 1'bz;

    // Two-flop synchronizers plus one history flop for clock edge detection.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            clk_sync_r <= 2'b11;
            dat_sync_r <= 2'b11;
            clk_prev_r <= 1'b1;
        end else begin
            clk_sync_r <= {clk_sync_r[0], M_CLK};
            dat_sync_r <= {dat_sync_r[0], M_Dat};
            clk_prev_r <= clk_sync_r[1];
        end
    end

    // Edge detect and saturating timeout increment.
    always_comb begin
        clk_fall_s = clk_prev_r & ~clk_sync_r[1];
        if (tmo_cnt_r == TMO_MAX) begin
            tmo_inc_s = tmo_cnt_r;
        end else begin
            tmo_inc_s = tmo_cnt_r + TW'(1);
        end
        timeout_s = (tmo_inc_s >= TMO_LIM);
    end

    // Transfer sequencer with registered line drives and status outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r     <= IDLE;
            cmd_r       <= 8'h00;
            par_r       <= 1'b0;
            bit_cnt_r   <= 4'd0;
            phase_cnt_r <= '0;
            tmo_cnt_r   <= '0;
            clk_low_r   <= 1'b0;
            dat_low_r   <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Err         <= 1'b0;
        end else begin
            Done <= 1'b0;
            Err  <= 1'b0;
            if ((state_r == SEND || state_r == ACK || state_r == RELEASE) && timeout_s) begin
                tmo_cnt_r <= tmo_inc_s;
                clk_low_r <= 1'b0;
                dat_low_r <= 1'b0;
                Err       <= 1'b1;
                Busy      <= 1'b0;
                state_r   <= IDLE;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (Start) begin
                            cmd_r       <= Cmd;
                            par_r       <= odd_parity(Cmd);
                            bit_cnt_r   <= 4'd0;
                            phase_cnt_r <= '0;
                            clk_low_r   <= 1'b1;
                            dat_low_r   <= 1'b0;
                            Busy        <= 1'b1;
                            state_r     <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (phase_cnt_r == INH_LAST) begin
                            phase_cnt_r <= '0;
                            dat_low_r   <= 1'b1;
                            state_r     <= RTS;
                        end else begin
                            phase_cnt_r <= phase_cnt_r + PW'(1);
                        end
                    end
                    RTS: begin
                        if (phase_cnt_r == RTS_LAST) begin
                            phase_cnt_r <= '0;
                            clk_low_r   <= 1'b0;
                            tmo_cnt_r   <= '0;
                            state_r     <= SEND;
                        end else begin
                            phase_cnt_r <= phase_cnt_r + PW'(1);
                        end
                    end
                    SEND: begin
                        tmo_cnt_r <= tmo_inc_s;
                        if (clk_fall_s) begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            // Edges 1..8 carry data LSB first, 9 parity, 10 the stop bit.
                            if (bit_cnt_r < 4'd8) begin
                                dat_low_r <= ~cmd_r[bit_cnt_r[2:0]];
                            end else if (bit_cnt_r == 4'd8) begin
                                dat_low_r <= ~par_r;
                            end else begin
                                dat_low_r <= 1'b0;
                                state_r   <= ACK;
                            end
                        end
                    end
                    ACK: begin
                        tmo_cnt_r <= tmo_inc_s;
                        if (clk_fall_s) begin
                            if (!dat_sync_r[1]) begin
                                state_r <= RELEASE;
                            end else begin
                                Err     <= 1'b1;
                                Busy    <= 1'b0;
                                state_r <= IDLE;
                            end
                        end
                    end
                    RELEASE: begin
                        tmo_cnt_r <= tmo_inc_s;
                        if (clk_sync_r[1] && dat_sync_r[1]) begin
                            Done    <= 1'b1;
                            Busy    <= 1'b0;
                            state_r <= IDLE;
                        end
                    end
                    default: begin
                        clk_low_r <= 1'b0;
                        dat_low_r <= 1'b0;
                        Busy      <= 1'b0;
                        state_r   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host while a
// scoreboard monitor checks each Done/Err outcome against queued expectations.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int RTS = 5;
    localparam int TMO = 600;
    localparam int P   = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] cmd;
    wire        m_clk_w;
    wire        m_dat_w;
    logic       busy, done, err;
    logic       dev_clk_low, dev_dat_low;

    pullup (m_clk_w);
    pullup (m_dat_w);
    assign m_clk_w = dev_clk_low ? 1'b0 : 1'bz;
    assign m_dat_w = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_tx #(.INHIBIT_CYC(INH), .RTS_CYC(RTS), .TIMEOUT_CYC(TMO)) dut (
        .Clk(clk), .Rst(rst), .Start(start), .Cmd(cmd),
        .M_CLK(m_clk_w), .M_Dat(m_dat_w),
        .Busy(busy), .Done(done), .Err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] outcome;   // 2'b10 Done, 2'b01 Err
        logic [9:0] frame;     // {stop, parity, cmd} as seen on the bus
        int         nbits;
        int         tmo_lat;   // -1 when no timeout is expected
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         rel_cyc = 0;
    bit         rel_seen = 1'b0;
    logic       busy_prev = 1'b0;
    logic       clk_bus_prev = 1'b1;
    logic [9:0] obs_frame = 10'h000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Scoreboard monitor: release timing plus one pop per Done/Err pulse.
    initial begin
        exp_t e;
        logic [9:0] mask;
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && busy_prev !== 1'b1) rel_seen = 1'b0;
            if (busy === 1'b1 && !rel_seen && clk_bus_prev === 1'b0 && m_clk_w === 1'b1) begin
                rel_seen = 1'b1;
                rel_cyc  = cyc;
            end
            if (done === 1'b1 || err === 1'b1) begin
                check("done_err_exclusive", {31'd0, done & err}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, done, err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    mask = 10'((1 << e.nbits) - 1);
                    check("outcome", {30'd0, done, err}, {30'd0, e.outcome});
                    check("busy_at_end", {31'd0, busy}, 32'd0);
                    check("frame", {22'd0, obs_frame & mask}, {22'd0, e.frame & mask});
                    if (e.tmo_lat >= 0) begin
                        check("timeout_latency", cyc - rel_cyc, e.tmo_lat);
                        check("lines_released", {30'd0, m_clk_w, m_dat_w}, 32'd3);
                    end
                end
            end
            busy_prev    = busy;
            clk_bus_prev = m_clk_w;
        end
    end

    // Device model: waits for request-to-send, then clocks up to max_edges edges.
    task automatic dev_xfer(input int max_edges, input bit ack_low, input int rst_edge);
        int w = 0;
        obs_frame = 10'h000;
        while (!(busy === 1'b1 && m_clk_w === 1'b1 && m_dat_w === 1'b0) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) begin
            fail_now("rts_wait");
            return;
        end
        repeat (4) @(negedge clk);
        for (int n = 1; n <= max_edges; n++) begin
            if (n == 11 && ack_low) begin
                dev_dat_low = 1'b1;
                repeat (2) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (P) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (P) @(negedge clk);
            if (n == 11) begin
                dev_dat_low = 1'b0;
            end else begin
                obs_frame[n-1] = m_dat_w;
            end
            if (n == rst_edge) begin
                rst = 1'b1;
                #1;
                check("rst_lines_z", {30'd0, m_clk_w, m_dat_w}, 32'd3);
                check("rst_busy", {31'd0, busy}, 32'd0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
    endtask

    task automatic issue(input logic [7:0] c, input logic [9:0] frame, input logic [1:0] oc,
                         input int nb, input int tl);
        exp_t e;
        e.outcome = oc;
        e.frame   = frame;
        e.nbits   = nb;
        e.tmo_lat = tl;
        exp_q.push_back(e);
        cmd   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int w = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && w < lim) begin
            @(negedge clk);
            w++;
        end
        if (w >= lim) fail_now("idle_wait");
    endtask

    logic [7:0] par_cmds [3]   = '{8'hFF, 8'h00, 8'h01};
    logic [9:0] par_frames [3] = '{10'h3FF, 10'h300, 10'h201};

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; cmd = 8'h00;
        dev_clk_low = 1'b0; dev_dat_low = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {29'd0, busy, done, err}, 32'd0);
        check("reset_lines", {30'd0, m_clk_w, m_dat_w}, 32'd3);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outputs", {29'd0, busy, done, err}, 32'd0);
        check("idle_lines", {30'd0, m_clk_w, m_dat_w}, 32'd3);

        issue(8'hF4, 10'h2F4, 2'b10, 10, -1);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        dev_xfer(11, 1'b1, 0);
        wait_idle(200);

        for (int i = 0; i < 3; i++) begin
            issue(par_cmds[i], par_frames[i], 2'b10, 10, -1);
            dev_xfer(11, 1'b1, 0);
            wait_idle(200);
        end

        issue(8'hA5, 10'h3A5, 2'b01, 10, -1);
        dev_xfer(11, 1'b0, 0);
        wait_idle(200);

        issue(8'h3C, 10'h33C, 2'b01, 4, TMO);
        dev_xfer(4, 1'b1, 0);
        wait_idle(2000);

        cmd = 8'h0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dev_xfer(11, 1'b1, 5);
        repeat (20) @(negedge clk);
        check("post_rst_idle", {29'd0, busy, done, err}, 32'd0);
        issue(8'h5A, 10'h35A, 2'b10, 10, -1);
        dev_xfer(11, 1'b1, 0);
        wait_idle(200);

        begin
            exp_t e;
            e.outcome = 2'b10; e.nbits = 10; e.tmo_lat = -1;
            e.frame = 10'h312; exp_q.push_back(e);
            e.frame = 10'h381; exp_q.push_back(e);
        end
        cmd = 8'h12; start = 1'b1;
        @(negedge clk);
        cmd = 8'h81;
        dev_xfer(11, 1'b1, 0);
        k = 0;
        while (busy === 1'b1 && k < 100) begin @(negedge clk); k++; end
        if (k >= 100) fail_now("held_busy_fall");
        k = 0;
        while (busy !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        check("held_restart_gap", k, 32'd1);
        start = 1'b0;
        dev_xfer(11, 1'b1, 0);
        wait_idle(200);
        repeat (60) @(negedge clk);
        check("no_third_transfer", {31'd0, busy}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
